ss_seq_master: RTL and testbench

Save-state sequencer: the initiator side of the mapper save-state port. On a host command it asserts `ss_act` and walks mapper register addresses 0..REG_CNT-1, either reading each `ss_rdat` byte into a host buffer (save) or writing buffer bytes into the mapper (load). For every register it generates one synthetic M2 cycle, so mappers latch restore data on the falling M2 edge exactly as they do during normal bus operation. It sits between the host/menu logic with its buffer RAM and the mapper's `ss_ctrl` / `cpu_dat` / `m2` inputs, which are muxed in while `ss_act=1`.

---
 rtl/ss_seq_master.sv | 194 +++++++++++++++++++
 tb/tb_ss_seq_master.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ss_seq_master.sv
// Save-state sequencer: walks mapper registers 0..REG_CNT-1 with one synthetic M2 cycle each.
// Define SS_SEQ_VERIFY_EN to add a read-back verify pass after every load.
module ss_seq_master #(
    parameter int REG_CNT = 128,
    parameter int HALF    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_save,
    input  logic       cmd_load,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] buf_addr,
    output logic [7:0] buf_wdat,
    output logic       buf_we,
    input  logic [7:0] buf_rdat,
    output logic       ss_act,
    output logic       ss_we,
    output logic [7:0] ss_addr,
    output logic [7:0] ss_wdat,
    output logic       ss_m2,
    input  logic [7:0] ss_rdat
);
    localparam int            CW         = $clog2(HALF);
    localparam logic [CW-1:0] CNT_LAST   = CW'(HALF - 1);
    localparam logic [CW-1:0] FETCH_LAST = CW'(1);
    localparam logic [7:0]    IDX_LAST   = 8'(REG_CNT - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SETUP,
        STROBE,
        STORE,
        NEXT,
`ifdef SS_SEQ_VERIFY_EN
        VERIFY,
`endif
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          load_q, load_d;
    logic [7:0]    wdat_q, wdat_d;
    logic [7:0]    samp_q, samp_d;
`ifdef SS_SEQ_VERIFY_EN
    logic          verify_q, verify_d;
    logic          err_q, err_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            load_q   <= 1'b0;
            wdat_q   <= '0;
            samp_q   <= '0;
`ifdef SS_SEQ_VERIFY_EN
            verify_q <= 1'b0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            load_q   <= load_d;
            wdat_q   <= wdat_d;
            samp_q   <= samp_d;
`ifdef SS_SEQ_VERIFY_EN
            verify_q <= verify_d;
            err_q    <= err_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        load_d   = load_q;
        wdat_d   = wdat_q;
        samp_d   = samp_q;
`ifdef SS_SEQ_VERIFY_EN
        verify_d = verify_q;
        err_d    = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                // Save has priority when both commands arrive together.
                if (cmd_save || cmd_load) begin
                    load_d  = !cmd_save;
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = cmd_save ? SETUP : FETCH;
`ifdef SS_SEQ_VERIFY_EN
                    verify_d = 1'b0;
                    err_d    = 1'b0;
`endif
                end
            end
            FETCH: begin
                if (cnt_q == FETCH_LAST) begin
                    cnt_d   = '0;
                    wdat_d  = buf_rdat;
                    state_d = SETUP;
`ifdef SS_SEQ_VERIFY_EN
                    if (verify_q) wdat_d = wdat_q;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SETUP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = STROBE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STROBE: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    samp_d  = ss_rdat;
                    state_d = load_q ? NEXT : STORE;
`ifdef SS_SEQ_VERIFY_EN
                    if (verify_q) state_d = VERIFY;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STORE: begin
                state_d = NEXT;
            end
            NEXT: begin
                // Terminal compare against REG_CNT-1 keeps the 8-bit index from wrapping.
                if (idx_q == IDX_LAST) begin
                    state_d = DONE;
`ifdef SS_SEQ_VERIFY_EN
                    if (load_q) begin
                        verify_d = 1'b1;
                        idx_d    = '0;
                        state_d  = FETCH;
                    end
`endif
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = load_q ? FETCH : SETUP;
                end
            end
`ifdef SS_SEQ_VERIFY_EN
            VERIFY: begin
                if (samp_q != buf_rdat) err_d = 1'b1;
                if (idx_q == IDX_LAST) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = FETCH;
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode straight from registered state so reset takes effect asynchronously.
    assign busy     = (state_q != IDLE) && (state_q != DONE);
    assign ss_act   = busy;
    assign done     = (state_q == DONE);
    assign ss_m2    = (state_q != STROBE);
    assign buf_we   = (state_q == STORE);
    assign buf_addr = idx_q;
    assign buf_wdat = samp_q;
    assign ss_addr  = idx_q;
    assign ss_wdat  = wdat_q;
`ifdef SS_SEQ_VERIFY_EN
    assign ss_we = load_q && !verify_q && ((state_q == SETUP) || (state_q == STROBE));
    assign err   = err_q;
`else
    assign ss_we = load_q && ((state_q == SETUP) || (state_q == STROBE));
    assign err   = 1'b0;
`endif

endmodule

// File: tb/tb_ss_seq_master.sv
// Self-checking bench for ss_seq_master: behavioural mapper and buffer models, random data.
// Verify-pass expectations follow SS_SEQ_VERIFY_EN when it is defined for the build.
module tb_ss_seq_master;
    localparam int N          = 4;
    localparam int H          = 4;
    localparam int NB         = 256;
    localparam int HB         = 2;
`ifdef SS_SEQ_VERIFY_EN
    localparam bit VERIFY_ON  = 1'b1;
`else
    localparam bit VERIFY_ON  = 1'b0;
`endif
    localparam int SAVE_LAT   = N * (2 * H + 2) + 1;
    localparam int LOAD_LAT   = (VERIFY_ON ? 2 : 1) * N * (2 * H + 3) + 1;
    localparam int SAVE_LAT_B = NB * (2 * HB + 2) + 1;

    logic       clk, rst_n;
    logic       cmd_save, cmd_load, busy, done, err, buf_we, ss_act, ss_we, ss_m2;
    logic [7:0] buf_addr, buf_wdat, buf_rdat, ss_addr, ss_wdat, ss_rdat;
    logic       cmd_save_b, cmd_load_b, busy_b, done_b, err_b, buf_we_b, ss_act_b, ss_we_b, ss_m2_b;
    logic [7:0] buf_addr_b, buf_wdat_b, buf_rdat_b, ss_addr_b, ss_wdat_b, ss_rdat_b;

    logic [7:0]  mreg[256];
    logic [7:0]  bufmem[256];
    logic [7:0]  bufB[256];
    logic [7:0]  expVals[256];
    logic [7:0]  dirSave[4];
    logic [7:0]  keyB;
    logic        dropBit7;
    logic [16:0] strobeQ[$];
    int          weCnt, weSeen, doneCnt, weCntB, maxAddrB;
    int          checks = 0;
    int          errors = 0;

    ss_seq_master #(.REG_CNT(N), .HALF(H)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_save(cmd_save), .cmd_load(cmd_load),
        .busy(busy), .done(done), .err(err),
        .buf_addr(buf_addr), .buf_wdat(buf_wdat), .buf_we(buf_we), .buf_rdat(buf_rdat),
        .ss_act(ss_act), .ss_we(ss_we), .ss_addr(ss_addr), .ss_wdat(ss_wdat),
        .ss_m2(ss_m2), .ss_rdat(ss_rdat)
    );

    ss_seq_master #(.REG_CNT(NB), .HALF(HB)) dut256 (
        .clk(clk), .rst_n(rst_n), .cmd_save(cmd_save_b), .cmd_load(cmd_load_b),
        .busy(busy_b), .done(done_b), .err(err_b),
        .buf_addr(buf_addr_b), .buf_wdat(buf_wdat_b), .buf_we(buf_we_b), .buf_rdat(buf_rdat_b),
        .ss_act(ss_act_b), .ss_we(ss_we_b), .ss_addr(ss_addr_b), .ss_wdat(ss_wdat_b),
        .ss_m2(ss_m2_b), .ss_rdat(ss_rdat_b)
    );

    always #5 clk = ~clk;

    // Mapper model: register file read combinationally, written on the falling M2 edge.
    assign ss_rdat   = mreg[ss_addr];
    assign ss_rdat_b = ss_addr_b ^ keyB;

    always @(negedge ss_m2) begin
        strobeQ.push_back({ss_we, ss_addr, ss_wdat});
        if (ss_we === 1'b1)
            mreg[ss_addr] = (dropBit7 && ss_addr == 8'd0) ? (ss_wdat & 8'h7F) : ss_wdat;
    end

    // Synchronous buffer RAMs with one cycle of read latency.
    always @(posedge clk) begin
        buf_rdat   <= bufmem[buf_addr];
        buf_rdat_b <= bufB[buf_addr_b];
        if (buf_we === 1'b1) bufmem[buf_addr] = buf_wdat;
        if (buf_we_b === 1'b1) bufB[buf_addr_b] = buf_wdat_b;
    end

    always @(negedge clk) begin
        if (buf_we === 1'b1) weCnt++;
        if (ss_we === 1'b1) weSeen++;
        if (done === 1'b1) doneCnt++;
        if (buf_we_b === 1'b1) begin
            weCntB++;
            if (int'(buf_addr_b) > maxAddrB) maxAddrB = int'(buf_addr_b);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulses a command, optionally injects a cmd_load while busy, and waits for done.
    task automatic applyStimulus(input bit s, input bit l, input int midLoad, output int lat);
        weCnt  = 0;
        weSeen = 0;
        strobeQ.delete();
        @(negedge clk);
        cmd_save = s;
        cmd_load = l;
        @(negedge clk);
        cmd_save = 1'b0;
        cmd_load = 1'b0;
        checkOutput("accept_busy", busy, 1);
        checkOutput("accept_ss_act", ss_act, 1);
        checkOutput("accept_err_clear", err, 0);
        lat = 1;
        while (done !== 1'b1 && lat < 3000) begin
            cmd_load = (lat == midLoad);
            @(negedge clk);
            lat++;
        end
        cmd_load = 1'b0;
        @(negedge clk);
        checkOutput("done_one_cycle", {done, busy, ss_act}, 0);
    endtask

    initial begin
        int lat, cyc, k, doneBefore;
        clk = 0; rst_n = 0; cmd_save = 0; cmd_load = 0; cmd_save_b = 0; cmd_load_b = 0;
        dropBit7 = 0; keyB = 8'($urandom);
        weCnt = 0; weSeen = 0; doneCnt = 0; weCntB = 0; maxAddrB = -1;
        dirSave[0] = 8'h01; dirSave[1] = 8'hFF; dirSave[2] = 8'h5A; dirSave[3] = 8'h00;
        for (int i = 0; i < 256; i++) begin
            mreg[i] = '0; bufmem[i] = '0; bufB[i] = '0; expVals[i] = '0;
        end
        #12;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_buf_we", buf_we, 0);
        checkOutput("rst_ss_act", ss_act, 0);
        checkOutput("rst_ss_we", ss_we, 0);
        checkOutput("rst_ss_m2", ss_m2, 1);
        checkOutput("rst_ss_addr", ss_addr, 0);
        checkOutput("rst_ss_wdat", ss_wdat, 0);
        checkOutput("rst_buf_addr", buf_addr, 0);
        checkOutput("rst_buf_wdat", buf_wdat, 0);
        @(negedge clk);
        rst_n = 1;

        $display("[TB] save sequences");
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < N; i++) begin
                expVals[i] = (t == 0) ? dirSave[i] : 8'($urandom);
                mreg[i]    = expVals[i];
            end
            applyStimulus(1'b1, 1'b0, 0, lat);
            checkOutput("save_latency", lat, SAVE_LAT);
            checkOutput("save_buf_we_count", weCnt, N);
            checkOutput("save_no_ss_we", weSeen, 0);
            checkOutput("save_m2_falls", strobeQ.size(), N);
            checkOutput("save_err", err, 0);
            for (int i = 0; i < N; i++) checkOutput($sformatf("save_buf%0d", i), bufmem[i], expVals[i]);
        end

        $display("[TB] load sequences");
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < N; i++) begin
                expVals[i] = 8'($urandom);
                if (t == 0 && i == 0) expVals[i] = 8'h80;
                if (t == 0 && i == 1) expVals[i] = 8'h01;
                bufmem[i] = expVals[i];
                mreg[i]   = ~expVals[i];
            end
            applyStimulus(1'b0, 1'b1, 0, lat);
            checkOutput("load_latency", lat, LOAD_LAT);
            checkOutput("load_no_buf_we", weCnt, 0);
            checkOutput("load_ss_we_cycles", weSeen, N * 2 * H);
            checkOutput("load_m2_falls", strobeQ.size(), (VERIFY_ON ? 2 : 1) * N);
            checkOutput("load_err", err, 0);
            k = 0;
            foreach (strobeQ[j]) begin
                if (strobeQ[j][16]) begin
                    checkOutput("load_strobe_addr", strobeQ[j][15:8], k);
                    checkOutput("load_strobe_data", strobeQ[j][7:0], expVals[k]);
                    k++;
                end
            end
            checkOutput("load_we_strobes", k, N);
            for (int i = 0; i < N; i++) checkOutput($sformatf("load_mreg%0d", i), mreg[i], expVals[i]);
        end

        $display("[TB] simultaneous commands and busy command");
        for (int i = 0; i < N; i++) begin
            expVals[i] = 8'($urandom);
            mreg[i]    = expVals[i];
        end
        applyStimulus(1'b1, 1'b1, 5, lat);
        checkOutput("both_latency", lat, SAVE_LAT);
        checkOutput("both_no_ss_we", weSeen, 0);
        checkOutput("both_buf_we_count", weCnt, N);
        for (int i = 0; i < N; i++) checkOutput($sformatf("both_buf%0d", i), bufmem[i], expVals[i]);
        repeat (4) @(negedge clk);
        checkOutput("busy_cmd_ignored", {busy, ss_act}, 0);

        $display("[TB] reset during load");
        strobeQ.delete();
        doneBefore = doneCnt;
        @(negedge clk);
        cmd_load = 1'b1;
        @(negedge clk);
        cmd_load = 1'b0;
        cyc = 0;
        while (!(ss_addr === 8'd2 && ss_m2 === 1'b0) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("rst_reach_reg2", cyc < 200, 1);
        #1 rst_n = 0;
        #1;
        checkOutput("rst_mid_ss_act", ss_act, 0);
        checkOutput("rst_mid_ss_m2", ss_m2, 1);
        checkOutput("rst_mid_busy", busy, 0);
        checkOutput("rst_mid_ss_addr", ss_addr, 0);
        repeat (3) @(negedge clk);
        rst_n = 1;
        repeat (3) @(negedge clk);
        checkOutput("rst_no_done", doneCnt - doneBefore, 0);
        for (int i = 0; i < N; i++) begin
            expVals[i] = 8'($urandom);
            mreg[i]    = expVals[i];
        end
        applyStimulus(1'b1, 1'b0, 0, lat);
        checkOutput("post_rst_first_addr", strobeQ.size() > 0 ? strobeQ[0][15:8] : 8'hEE, 0);
        checkOutput("post_rst_latency", lat, SAVE_LAT);
        for (int i = 0; i < N; i++) checkOutput($sformatf("post_rst_buf%0d", i), bufmem[i], expVals[i]);

        $display("[TB] verify with a lossy mapper register");
        dropBit7 = 1'b1;
        for (int i = 0; i < N; i++) begin
            expVals[i] = (i == 0) ? 8'h80 : 8'($urandom);
            bufmem[i]  = expVals[i];
        end
        applyStimulus(1'b0, 1'b1, 0, lat);
        checkOutput("verify_latency", lat, LOAD_LAT);
        checkOutput("verify_mreg0", mreg[0], expVals[0] & 8'h7F);
        checkOutput("verify_err", err, VERIFY_ON);
        dropBit7 = 1'b0;
        applyStimulus(1'b1, 1'b0, 0, lat);
        checkOutput("verify_err_cleared", err, 0);

        $display("[TB] 256-register save");
        @(negedge clk);
        cmd_save_b = 1'b1;
        @(negedge clk);
        cmd_save_b = 1'b0;
        checkOutput("b256_busy", busy_b, 1);
        lat = 1;
        while (done_b !== 1'b1 && lat < 3000) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("b256_latency", lat, SAVE_LAT_B);
        checkOutput("b256_last_addr", ss_addr_b, 8'hFF);
        checkOutput("b256_we_count", weCntB, NB);
        checkOutput("b256_max_addr", maxAddrB, 255);
        checkOutput("b256_no_ss_we", ss_we_b, 0);
        @(negedge clk);
        checkOutput("b256_idle", {done_b, busy_b, ss_act_b}, 0);
        k = 0;
        for (int i = 0; i < NB; i++) if (bufB[i] !== (8'(i) ^ keyB)) k++;
        checkOutput("b256_buf_bad_bytes", k, 0);
        checkOutput("b256_buf_first", bufB[0], keyB);
        checkOutput("b256_buf_last", bufB[255], 8'hFF ^ keyB);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
